// File: rtl/spi_slave_param_if.sv
// Bus bundle for the parametrised SPI slave.
// Carries the serial pins (SS_n, MOSI, MISO), the memory-side read-data handshake
// (tx_valid, tx_data) and the deserialised frame outputs (rx_valid, rx_data, busy,
// frame_err).
//   slave  modport: the SPI slave block (drives rx_*, MISO, busy, frame_err).
//   master modport: the SPI master / memory side (drives SS_n, MOSI, tx_*).
interface spi_slave_param_if #(
   parameter int DATA_W = 8
);
   logic              SS_n;
   logic              MOSI;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              rx_valid;
   logic [DATA_W+1:0] rx_data;
   logic              MISO;
   logic              busy;
   logic              frame_err;

   modport slave (
      input  SS_n, MOSI, tx_valid, tx_data,
      output rx_valid, rx_data, MISO, busy, frame_err
   );

   modport master (
      output SS_n, MOSI, tx_valid, tx_data,
      input  rx_valid, rx_data, MISO, busy, frame_err
   );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave. Each frame is DATA_W+2 bits, MSB first: a 2-bit command
// followed by DATA_W payload bits, one bit per clk rising edge while SS_n is low.
// A leading 0 is a write; a leading 1 is a read address the first time and a read
// data request once an address has been seen, after which tx_data is returned on MISO.
// Ports:
//   clk    system clock, also the SPI bit clock
//   rst_n  asynchronous active-low reset
//   bus    spi_slave_param_if.slave: SS_n, MOSI, tx_valid, tx_data in;
//          rx_valid, rx_data {cmd, payload}, MISO, busy, frame_err out
module spi_slave_param #(
   parameter int DATA_W      = 8,
   parameter int TX_WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_slave_param_if.slave bus
);
   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W);
   // The wait counter must also be able to reach TX_WAIT_MAX-1 if that exceeds the frame size.
   localparam int WAIT_W  = ($clog2(TX_WAIT_MAX + 1) > CNT_W) ? $clog2(TX_WAIT_MAX + 1) : CNT_W;

   localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]  TX_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                rd_addr_seen_q, rd_addr_seen_d;
   logic                rx_valid_q, rx_valid_d;
   logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
   logic                miso_q, miso_d;
   logic                busy_q, busy_d;
   logic                frame_err_q, frame_err_d;
   logic [DATA_W:0]     rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      rd_addr_seen_d = rd_addr_seen_q;
      rx_valid_d     = 1'b0;
      rx_data_d      = rx_data_q;
      miso_d         = 1'b0;
      frame_err_d    = 1'b0;
      rx_sr_d        = rx_sr_q;
      tx_sr_d        = tx_sr_q;

      // Deselect outside IDLE wins over everything else, including a last-bit sample
      // or a tx_valid arriving on the same edge.
      if (state_q != IDLE && bus.SS_n) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         bit_cnt_d   = '0;
         wait_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_d  = '0;
               wait_cnt_d = '0;
               if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
               rx_sr_d = {rx_sr_q[DATA_W-1:0], bus.MOSI};
               // Only the first command bit routes; the second is left for downstream decode.
               if (!bus.MOSI)           state_d = WRITE;
               else if (rd_addr_seen_q) state_d = READ_DATA;
               else                     state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               rx_sr_d = {rx_sr_q[DATA_W-1:0], bus.MOSI};
               if (bit_cnt_q == RX_LAST) begin
                  rx_data_d  = {rx_sr_q, bus.MOSI};
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  if (state_q == READ_DATA) begin
                     state_d = TX_WAIT;
                  end else begin
                     state_d = IDLE;
                     if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            TX_WAIT: begin
               if (bus.tx_valid) begin
                  // The MSB goes straight onto MISO; the rest waits in the shift register.
                  miso_d     = bus.tx_data[DATA_W-1];
                  tx_sr_d    = bus.tx_data << 1;
                  wait_cnt_d = '0;
                  state_d    = TX_SHIFT;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  frame_err_d = 1'b1;
                  wait_cnt_d  = '0;
                  state_d     = IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
            TX_SHIFT: begin
               if (bit_cnt_q == TX_LAST) begin
                  bit_cnt_d      = '0;
                  rd_addr_seen_d = 1'b0;
                  state_d        = IDLE;
               end else begin
                  miso_d    = tx_sr_q[DATA_W-1];
                  tx_sr_d   = tx_sr_q << 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         wait_cnt_q     <= '0;
         rd_addr_seen_q <= 1'b0;
         rx_valid_q     <= 1'b0;
         rx_data_q      <= '0;
         miso_q         <= 1'b0;
         busy_q         <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         rd_addr_seen_q <= rd_addr_seen_d;
         rx_valid_q     <= rx_valid_d;
         rx_data_q      <= rx_data_d;
         miso_q         <= miso_d;
         busy_q         <= busy_d;
         frame_err_q    <= frame_err_d;
      end
   end

   // Shift registers are pure datapath; their contents only matter once a frame is under way.
   always_ff @(posedge clk) begin
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
   end

   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.MISO      = miso_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_param.sv
module tb_spi_slave_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   rd_seen_m = 1'b0;

   int rx_cnt8 = 0, rx_edge8 = 0, fe_cnt8 = 0, fe_edge8 = 0, miso_hi8 = 0;
   int rx_cnt16 = 0, rx_edge16 = 0;

   spi_slave_param_if #(.DATA_W(8))  if8 ();
   spi_slave_param_if #(.DATA_W(16)) if16 ();

   spi_slave_param #(.DATA_W(8), .TX_WAIT_MAX(15)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.slave));
   spi_slave_param #(.DATA_W(16), .TX_WAIT_MAX(15)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(if16.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse/level monitor, sampled just after each edge; cyc is the edge number.
   always @(posedge clk) begin
      #1;
      if (if8.rx_valid === 1'b1) begin rx_cnt8++; rx_edge8 = cyc; end
      if (if8.frame_err === 1'b1) begin fe_cnt8++; fe_edge8 = cyc; end
      if (if8.MISO === 1'b1) miso_hi8++;
      if (if16.rx_valid === 1'b1) begin rx_cnt16++; rx_edge16 = cyc; end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a leading 1 is an address until one has been seen, then a data
   // request that ends up waiting for tx_data. Returns 1 when the slave should stay busy.
   function automatic bit model_frame(input logic cmd1);
      bit to_tx;
      to_tx = cmd1 && rd_seen_m;
      if (cmd1 && !rd_seen_m) rd_seen_m = 1'b1;
      return to_tx;
   endfunction

   task automatic set_ss(input int w, input logic v);
      if (w == 16) if16.SS_n = v; else if8.SS_n = v;
   endtask

   task automatic set_bit(input int w, input logic m, input logic tv);
      if (w == 16) begin if16.MOSI = m; if16.tx_valid = tv; if16.tx_data = 16'($urandom); end
      else begin if8.MOSI = m; if8.tx_valid = tv; if8.tx_data = 8'($urandom); end
   endtask

   // Called at a negedge; returns at the negedge after the last (or aborting) edge.
   // k is the edge at which the idle slave sees SS_n low.
   task automatic send_frame(input int w, input logic [17:0] frame, input int abort_at,
                             input bit hold_low, output int k);
      set_ss(w, 1'b0);
      k = cyc + 1;
      @(negedge clk);
      for (int i = 0; i < w + 2; i++) begin
         set_bit(w, frame[w + 1 - i], 1'($urandom));
         if (i == abort_at) begin
            set_ss(w, 1'b1);
            @(negedge clk);
            set_bit(w, 1'b0, 1'b0);
            return;
         end
         @(negedge clk);
      end
      set_bit(w, 1'b0, 1'b0);
      if (!hold_low) set_ss(w, 1'b1);
   endtask

   // Supplies tx_data after 'delay' idle wait cycles and collects the returned MISO bits.
   task automatic serve_tx(input logic [7:0] t, input int delay, output logic [7:0] got,
                           output logic tail_miso, output logic tail_busy);
      repeat (delay) @(negedge clk);
      if8.tx_valid = 1'b1;
      if8.tx_data  = t;
      @(negedge clk);
      if8.tx_valid = 1'b0;
      if8.tx_data  = 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
         got[i] = if8.MISO;
         @(negedge clk);
      end
      tail_miso = if8.MISO;
      tail_busy = if8.busy;
      if8.SS_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (if8.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", if8.rx_valid); end
      vectors++; if (if8.rx_data !== 10'h0) begin miscompares++; $display("FAIL reset_rx_data: got %h want 000", if8.rx_data); end
      vectors++; if (if8.MISO !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", if8.MISO); end
      vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
      vectors++; if (if8.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", if8.frame_err); end
      vectors++; if (if16.rx_data !== 18'h0) begin miscompares++; $display("FAIL reset_rx_data16: got %h want 0", if16.rx_data); end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", if8.busy); end
   endtask

   task automatic test_write();
      logic [9:0] f;
      int k, c0, m0;
      for (int n = 0; n < 6; n++) begin
         f  = (n == 0) ? 10'h0A5 : {1'b0, 1'($urandom), 8'($urandom)};
         c0 = rx_cnt8;
         m0 = miso_hi8;
         send_frame(8, 18'(f), -1, 1'b0, k);
         vectors++; if (if8.rx_valid !== 1'b1) begin miscompares++; $display("FAIL write_rx_valid: got %b want 1", if8.rx_valid); end
         vectors++; if (if8.rx_data !== f) begin miscompares++; $display("FAIL write_rx_data: got %h want %h", if8.rx_data, f); end
         @(negedge clk);
         vectors++; if (if8.rx_valid !== 1'b0) begin miscompares++; $display("FAIL write_rx_valid_width: got %b want 0", if8.rx_valid); end
         vectors++; if (rx_cnt8 - c0 !== 1) begin miscompares++; $display("FAIL write_pulses: got %0d want 1", rx_cnt8 - c0); end
         vectors++; if (rx_edge8 !== k + 10) begin miscompares++; $display("FAIL write_latency: got edge %0d want %0d", rx_edge8, k + 10); end
         vectors++; if (miso_hi8 !== m0) begin miscompares++; $display("FAIL write_miso: got %0d high cycles want 0", miso_hi8 - m0); end
      end
   endtask

   task automatic test_read();
      logic [9:0] fa, fd;
      logic [7:0] t, got;
      logic tm, tb;
      bit exp_tx;
      int k;
      for (int n = 0; n < 3; n++) begin
         fa = (n == 0) ? 10'h23C : {1'b1, 1'($urandom), 8'($urandom)};
         exp_tx = model_frame(fa[9]);
         send_frame(8, 18'(fa), -1, 1'b0, k);
         vectors++; if (if8.rx_data !== fa) begin miscompares++; $display("FAIL read_addr_data: got %h want %h", if8.rx_data, fa); end
         vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL read_addr_busy: got %b want %b", if8.busy, exp_tx); end
         fd = (n == 0) ? 10'h300 : {1'b1, 1'($urandom), 8'($urandom)};
         exp_tx = model_frame(fd[9]);
         send_frame(8, 18'(fd), -1, 1'b1, k);
         vectors++; if (if8.rx_data !== fd) begin miscompares++; $display("FAIL read_data_frame: got %h want %h", if8.rx_data, fd); end
         vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL read_data_busy: got %b want %b", if8.busy, exp_tx); end
         t = (n == 0) ? 8'hC3 : 8'($urandom);
         serve_tx(t, (n == 0) ? 1 : int'($urandom_range(0, 6)), got, tm, tb);
         rd_seen_m = 1'b0;
         vectors++; if (got !== t) begin miscompares++; $display("FAIL read_miso_bits: got %h want %h", got, t); end
         vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL read_miso_tail: got %b want 0", tm); end
         vectors++; if (tb !== 1'b0) begin miscompares++; $display("FAIL read_busy_tail: got %b want 0", tb); end
      end
   endtask

   task automatic test_abort();
      logic [9:0] f, prev;
      int k, c0, fe0, m0;
      bit exp_tx;
      for (int n = 0; n < 2; n++) begin
         prev = if8.rx_data;
         c0   = rx_cnt8;
         fe0  = fe_cnt8;
         f    = {1'b0, 1'($urandom), 8'($urandom)};
         send_frame(8, 18'(f), (n == 0) ? 5 : 9, 1'b0, k);
         vectors++; if (if8.frame_err !== 1'b1) begin miscompares++; $display("FAIL abort%0d_frame_err: got %b want 1", n, if8.frame_err); end
         @(negedge clk);
         vectors++; if (fe_cnt8 - fe0 !== 1) begin miscompares++; $display("FAIL abort%0d_err_pulses: got %0d want 1", n, fe_cnt8 - fe0); end
         vectors++; if (rx_cnt8 !== c0) begin miscompares++; $display("FAIL abort%0d_rx_valid: got %0d pulses want 0", n, rx_cnt8 - c0); end
         vectors++; if (if8.rx_data !== prev) begin miscompares++; $display("FAIL abort%0d_rx_hold: got %h want %h", n, if8.rx_data, prev); end
         vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL abort%0d_busy: got %b want 0", n, if8.busy); end
      end
      f = {1'b0, 1'($urandom), 8'($urandom)};
      send_frame(8, 18'(f), -1, 1'b0, k);
      vectors++; if (if8.rx_data !== f) begin miscompares++; $display("FAIL abort_recover: got %h want %h", if8.rx_data, f); end
      // Deselect together with tx_valid while waiting for read data.
      exp_tx = model_frame(1'b1);
      send_frame(8, 18'({2'b10, 8'($urandom)}), -1, 1'b0, k);
      exp_tx = model_frame(1'b1);
      send_frame(8, 18'({2'b11, 8'($urandom)}), -1, 1'b1, k);
      vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL abort_tx_wait_busy: got %b want %b", if8.busy, exp_tx); end
      m0  = miso_hi8;
      fe0 = fe_cnt8;
      if8.tx_valid = 1'b1;
      if8.tx_data  = 8'hFF;
      if8.SS_n     = 1'b1;
      @(negedge clk);
      if8.tx_valid = 1'b0;
      vectors++; if (if8.frame_err !== 1'b1) begin miscompares++; $display("FAIL abort_tx_frame_err: got %b want 1", if8.frame_err); end
      repeat (3) @(negedge clk);
      vectors++; if (miso_hi8 !== m0) begin miscompares++; $display("FAIL abort_tx_miso: got %0d high cycles want 0", miso_hi8 - m0); end
      vectors++; if (fe_cnt8 - fe0 !== 1) begin miscompares++; $display("FAIL abort_tx_err_pulses: got %0d want 1", fe_cnt8 - fe0); end
   endtask

   task automatic test_timeout();
      logic [9:0] fd;
      logic [7:0] t, got;
      logic tm, tb;
      bit exp_tx, seen;
      int k, e;
      fd = {2'b11, 8'($urandom)};
      exp_tx = model_frame(fd[9]);
      send_frame(8, 18'(fd), -1, 1'b1, k);
      e = k + 10;
      vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL timeout_wait_busy: got %b want %b", if8.busy, exp_tx); end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (if8.frame_err === 1'b1) seen = 1'b1;
      end
      if8.SS_n = 1'b1;
      vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL timeout_missing: got no frame_err within 40 cycles want one"); end
      vectors++; if (fe_edge8 !== e + 15) begin miscompares++; $display("FAIL timeout_edge: got edge %0d want %0d", fe_edge8, e + 15); end
      vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b want 0", if8.busy); end
      @(negedge clk);
      // Retry: the address is still remembered.
      fd = {1'b1, 1'($urandom), 8'($urandom)};
      exp_tx = model_frame(fd[9]);
      send_frame(8, 18'(fd), -1, 1'b1, k);
      vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL retry_busy: got %b want %b", if8.busy, exp_tx); end
      vectors++; if (if8.rx_data !== fd) begin miscompares++; $display("FAIL retry_rx_data: got %h want %h", if8.rx_data, fd); end
      t = 8'($urandom);
      serve_tx(t, 0, got, tm, tb);
      rd_seen_m = 1'b0;
      vectors++; if (got !== t) begin miscompares++; $display("FAIL retry_miso_bits: got %h want %h", got, t); end
      vectors++; if (tb !== 1'b0) begin miscompares++; $display("FAIL retry_busy_tail: got %b want 0", tb); end
   endtask

   task automatic test_reset_mid();
      logic [9:0] f;
      bit exp_tx;
      int k;
      exp_tx = model_frame(1'b1);
      send_frame(8, 18'({1'b1, 1'($urandom), 8'($urandom)}), -1, 1'b0, k);
      exp_tx = model_frame(1'b1);
      send_frame(8, 18'({1'b1, 1'($urandom), 8'($urandom)}), -1, 1'b1, k);
      if8.tx_valid = 1'b1;
      if8.tx_data  = 8'hFF;
      @(negedge clk);
      if8.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (if8.MISO !== 1'b1) begin miscompares++; $display("FAIL midreset_pre_miso: got %b want 1", if8.MISO); end
      rst_n = 1'b0;
      #1;
      vectors++; if (if8.MISO !== 1'b0) begin miscompares++; $display("FAIL midreset_miso: got %b want 0", if8.MISO); end
      vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", if8.busy); end
      vectors++; if (if8.rx_data !== 10'h0) begin miscompares++; $display("FAIL midreset_rx_data: got %h want 000", if8.rx_data); end
      vectors++; if (if8.rx_valid !== 1'b0 || if8.frame_err !== 1'b0) begin miscompares++; $display("FAIL midreset_pulses: got rx_valid %b frame_err %b want 0 0", if8.rx_valid, if8.frame_err); end
      rd_seen_m = 1'b0;
      if8.SS_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      f = {1'b1, 1'($urandom), 8'($urandom)};
      exp_tx = model_frame(f[9]);
      send_frame(8, 18'(f), -1, 1'b0, k);
      vectors++; if (if8.busy !== exp_tx) begin miscompares++; $display("FAIL postreset_route: got busy %b want %b", if8.busy, exp_tx); end
      vectors++; if (if8.rx_data !== f) begin miscompares++; $display("FAIL postreset_rx_data: got %h want %h", if8.rx_data, f); end
   endtask

   task automatic test_back_to_back();
      logic [17:0] g;
      logic [9:0]  f;
      int k, c0;
      c0 = rx_cnt16;
      send_frame(16, 18'h1BEEF, -1, 1'b1, k);
      vectors++; if (if16.rx_data !== 18'h1BEEF) begin miscompares++; $display("FAIL w16_rx_data: got %h want 1beef", if16.rx_data); end
      vectors++; if (rx_edge16 !== k + 18) begin miscompares++; $display("FAIL w16_latency: got edge %0d want %0d", rx_edge16, k + 18); end
      g = {1'b0, 1'($urandom), 16'($urandom)};
      send_frame(16, g, -1, 1'b0, k);
      vectors++; if (if16.rx_data !== g) begin miscompares++; $display("FAIL b2b16_rx_data: got %h want %h", if16.rx_data, g); end
      vectors++; if (rx_edge16 !== k + 18) begin miscompares++; $display("FAIL b2b16_latency: got edge %0d want %0d", rx_edge16, k + 18); end
      @(negedge clk);
      vectors++; if (rx_cnt16 - c0 !== 2) begin miscompares++; $display("FAIL b2b16_pulses: got %0d want 2", rx_cnt16 - c0); end
      for (int n = 0; n < 3; n++) begin
         f = {1'b0, 1'($urandom), 8'($urandom)};
         send_frame(8, 18'(f), -1, (n < 2), k);
         vectors++; if (if8.rx_data !== f) begin miscompares++; $display("FAIL b2b8_rx_data%0d: got %h want %h", n, if8.rx_data, f); end
         vectors++; if (rx_edge8 !== k + 10) begin miscompares++; $display("FAIL b2b8_latency%0d: got edge %0d want %0d", n, rx_edge8, k + 10); end
      end
      @(negedge clk);
      vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL b2b8_busy: got %b want 0", if8.busy); end
   endtask

   initial begin
      if8.SS_n = 1'b1;  if8.MOSI = 1'b0;  if8.tx_valid = 1'b0;  if8.tx_data = '0;
      if16.SS_n = 1'b1; if16.MOSI = 1'b0; if16.tx_valid = 1'b0; if16.tx_data = '0;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
